// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default word width and
// address map (also used by the CPU fetch path), FSM state type, counter sizing.
package imem_loader_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned BASE_ADDR_DEF = 32'h0000_0000;
    localparam int unsigned ADDR_STEP_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HOLD = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/imem_loader_counter.sv
// Synchronous up-counter with clear, enable and a terminal-count compare
// against a run-time terminal value.
module loader_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory while holding the CPU in
// reset, then releases it after a hold window and optionally runs it for a budget.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned XLEN            = XLEN_DEF,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned BASE_ADDR       = BASE_ADDR_DEF,
    parameter int unsigned ADDR_STEP       = ADDR_STEP_DEF,
    parameter bit          LEN_FROM_HEADER = 1'b1,
    parameter int unsigned RST_HOLD        = 1,
    parameter int unsigned RUN_CYCLES      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [XLEN-1:0]              s_data,
    output logic                         IM_we,
    output logic [XLEN-1:0]              IM_addr,
    output logic [XLEN-1:0]              IM_data,
    output logic                         cpu_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   words_loaded
);

    localparam int unsigned WW = $clog2(DEPTH + 1);
    localparam int unsigned HW = cnt_width(RST_HOLD);
    localparam int unsigned RW = cnt_width(RUN_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'((RST_HOLD == 0) ? 0 : RST_HOLD - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);

    state_e            state_q;
    state_e            state_d;
    logic [WW-1:0]     n_q;
    logic              s_ready_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              im_we_q;
    logic [XLEN-1:0]   im_addr_q;
    logic [XLEN-1:0]   im_data_q;

    logic              accept;
    logic              start_ok;
    logic              hdr_bad;
    logic              in_load;
    logic              in_hold;
    logic              in_run;

    logic [WW-1:0]     idx_cnt;
    logic              idx_tc;
    logic [HW-1:0]     hold_cnt;
    logic              hold_tc;
    logic [RW-1:0]     run_cnt;
    logic              run_tc;
    logic              unused_cnt;

    assign accept   = s_valid && s_ready_q;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));
    assign hdr_bad  = (s_data == '0) || (s_data > XLEN'(DEPTH));
    assign in_load  = (state_q == ST_LOAD);
    assign in_hold  = (state_q == ST_HOLD);
    assign in_run   = (state_q == ST_RUN);

    // Word index doubles as the words_loaded count: it advances on the same
    // edge that registers the IM write, so both become visible together.
    loader_counter #(.WIDTH(WW)) u_idx_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_ok),
        .en_i   (in_load && accept),
        .term_i (n_q - 1'b1),
        .cnt_o  (idx_cnt),
        .tc_o   (idx_tc)
    );

    loader_counter #(.WIDTH(HW)) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_hold),
        .en_i   (in_hold),
        .term_i (HOLD_LAST),
        .cnt_o  (hold_cnt),
        .tc_o   (hold_tc)
    );

    loader_counter #(.WIDTH(RW)) u_run_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!in_run),
        .en_i   (in_run && (RUN_CYCLES != 0)),
        .term_i (RUN_LAST),
        .cnt_o  (run_cnt),
        .tc_o   (run_tc)
    );

    assign unused_cnt = ^{hold_cnt, run_cnt};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = LEN_FROM_HEADER ? ST_HDR : ST_LOAD;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    state_d = hdr_bad ? ST_ERR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && idx_tc) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_tc) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((RUN_CYCLES != 0) && run_tc) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All status outputs are decoded from the next state so they change on
    // the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            s_ready_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            im_we_q   <= 1'b0;
            im_addr_q <= XLEN'(BASE_ADDR);
            im_data_q <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == ST_HDR) || (state_d == ST_LOAD);
            cpu_rst_q <= !((state_d == ST_RUN) || (state_d == ST_DONE));
            busy_q    <= (state_d == ST_HDR) || (state_d == ST_LOAD) ||
                         (state_d == ST_HOLD) || (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            err_q     <= (state_d == ST_ERR);
            im_we_q   <= 1'b0;

            if (start_ok) begin
                n_q <= WW'(DEPTH);
            end
            if ((state_q == ST_HDR) && accept && !hdr_bad) begin
                n_q <= s_data[WW-1:0];
            end
            if (in_load && accept) begin
                im_we_q   <= 1'b1;
                im_addr_q <= XLEN'(BASE_ADDR) + XLEN'(idx_cnt) * XLEN'(ADDR_STEP);
                im_data_q <= s_data;
            end
        end
    end

    assign s_ready      = s_ready_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign IM_we        = im_we_q;
    assign IM_addr      = im_addr_q;
    assign IM_data      = im_data_q;
    assign words_loaded = idx_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: header-mode loader (table of images, errors, restart,
// mid-load reset) and a fixed-length loader at a non-zero base address.
module tb_imem_loader;

    localparam int unsigned H_DEPTH = 16;
    localparam int unsigned H_HOLD  = 2;
    localparam int unsigned H_RUN   = 12;
    localparam int unsigned F_DEPTH = 8;
    localparam int unsigned F_BASE  = 32'h100;

    typedef struct {
        logic [31:0] hdr;
        int unsigned n;
        bit          throttle;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // header-mode instance
    logic        h_rst = 1'b1, h_start = 1'b0, h_valid = 1'b0;
    logic [31:0] h_data = '0;
    logic        h_ready, h_we, h_cpu_rst, h_busy, h_done, h_err;
    logic [31:0] h_addr, h_imdata;
    logic [4:0]  h_wl;

    // fixed-length instance
    logic        f_rst = 1'b1, f_start = 1'b0, f_valid = 1'b0;
    logic [31:0] f_data = '0;
    logic        f_ready, f_we, f_cpu_rst, f_busy, f_done, f_err;
    logic [31:0] f_addr, f_imdata;
    logic [3:0]  f_wl;

    imem_loader #(
        .XLEN(32), .DEPTH(H_DEPTH), .BASE_ADDR(0), .ADDR_STEP(4),
        .LEN_FROM_HEADER(1'b1), .RST_HOLD(H_HOLD), .RUN_CYCLES(H_RUN)
    ) u_hdr (
        .clk(clk), .rst(h_rst), .start(h_start), .s_valid(h_valid), .s_ready(h_ready),
        .s_data(h_data), .IM_we(h_we), .IM_addr(h_addr), .IM_data(h_imdata),
        .cpu_rst(h_cpu_rst), .busy(h_busy), .done(h_done), .err(h_err),
        .words_loaded(h_wl)
    );

    imem_loader #(
        .XLEN(32), .DEPTH(F_DEPTH), .BASE_ADDR(F_BASE), .ADDR_STEP(4),
        .LEN_FROM_HEADER(1'b0), .RST_HOLD(1), .RUN_CYCLES(0)
    ) u_fix (
        .clk(clk), .rst(f_rst), .start(f_start), .s_valid(f_valid), .s_ready(f_ready),
        .s_data(f_data), .IM_we(f_we), .IM_addr(f_addr), .IM_data(f_imdata),
        .cpu_rst(f_cpu_rst), .busy(f_busy), .done(f_done), .err(f_err),
        .words_loaded(f_wl)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned h_wr   = 0;
    int unsigned f_wr   = 0;
    wr_t         h_q[$];
    wr_t         f_q[$];
    vec_t        vecs[7];
    logic [31:0] spec_w[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: each IM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (h_we) begin
            h_wr++;
            if (h_q.size() == 0) begin
                chk("h_unexpected_we", 32'(h_we), 32'd0);
            end else begin
                e = h_q.pop_front();
                chk("h_wr_addr", h_addr, e.addr);
                chk("h_wr_data", h_imdata, e.data);
            end
        end
        if (f_we) begin
            f_wr++;
            if (f_q.size() == 0) begin
                chk("f_unexpected_we", 32'(f_we), 32'd0);
            end else begin
                e = f_q.pop_front();
                chk("f_wr_addr", f_addr, e.addr);
                chk("f_wr_data", f_imdata, e.data);
            end
        end
    end

    task automatic h_load(input int unsigned vi);
        logic [31:0] w[$];
        int unsigned wr0, sent, c, n;
        bit          v;
        n   = vecs[vi].n;
        wr0 = h_wr;
        for (int unsigned i = 0; i < n; i++) begin
            if (vi == 0) w.push_back(spec_w[i]);
            else         w.push_back($urandom);
        end

        @(negedge clk); h_start = 1'b1;
        @(negedge clk); h_start = 1'b0;
        chk("start_cpu_rst", 32'(h_cpu_rst), 32'd1);
        chk("start_ready", 32'(h_ready), 32'd1);
        chk("start_busy", 32'(h_busy), 32'd1);
        chk("start_done_clr", 32'(h_done), 32'd0);
        chk("start_err_clr", 32'(h_err), 32'd0);
        chk("start_wl_clr", 32'(h_wl), 32'd0);
        h_valid = 1'b1;
        h_data  = vecs[vi].hdr;
        @(negedge clk);

        if (vecs[vi].exp_err) begin
            h_data = 32'hDEAD_BEEF;
            chk("err_flag", 32'(h_err), 32'd1);
            chk("err_cpu_rst", 32'(h_cpu_rst), 32'd1);
            chk("err_ready", 32'(h_ready), 32'd0);
            chk("err_busy", 32'(h_busy), 32'd0);
            repeat (3) @(negedge clk);
            h_valid = 1'b0;
            chk("err_no_writes", h_wr - wr0, 32'd0);
            chk("err_wl", 32'(h_wl), 32'd0);
            chk("err_sticky", 32'(h_err), 32'd1);
            return;
        end

        for (int unsigned i = 0; i < n; i++) h_q.push_back('{addr: 32'(i * 4), data: w[i]});

        sent = 0;
        c    = 0;
        while (sent < n && c < 4 * n + 8) begin
            chk("load_ready", 32'(h_ready), 32'd1);
            v       = !vecs[vi].throttle || (c % 2 == 0);
            h_valid = v;
            h_data  = v ? w[sent] : (32'hBAD0_0000 | c);
            @(negedge clk);
            if (v) sent++;
            c++;
        end
        chk("load_budget", sent, n);

        // A word offered after the last acceptance must not be taken.
        h_valid = 1'b1;
        h_data  = 32'hFFFF_FFFF;
        chk("hold_ready_low", 32'(h_ready), 32'd0);
        chk("hold_last_we", 32'(h_we), 32'd1);
        chk("hold_busy", 32'(h_busy), 32'd1);
        for (int unsigned k = 0; k < H_HOLD; k++) begin
            chk("hold_cpu_rst", 32'(h_cpu_rst), 32'd1);
            @(negedge clk);
        end
        h_valid = 1'b0;
        chk("run_cpu_rst", 32'(h_cpu_rst), 32'd0);
        chk("run_wl", 32'(h_wl), n);
        chk("run_busy", 32'(h_busy), 32'd1);
        repeat (H_RUN - 1) @(negedge clk);
        chk("run_not_done", 32'(h_done), 32'd0);
        chk("run_cpu_rst_late", 32'(h_cpu_rst), 32'd0);
        @(negedge clk);
        chk("done_flag", 32'(h_done), 32'd1);
        chk("done_cpu_rst", 32'(h_cpu_rst), 32'd0);
        chk("done_busy", 32'(h_busy), 32'd0);
        chk("load_write_count", h_wr - wr0, n);
        chk("load_sb_empty", h_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] fw[F_DEPTH];
        logic [31:0] mw[3];
        int unsigned wr0;

        spec_w[0] = 32'h0050_0093;
        spec_w[1] = 32'h0010_0113;
        spec_w[2] = 32'h0020_81B3;
        vecs[0] = '{hdr: 32'd3,           n: 3,       throttle: 1'b0, exp_err: 1'b0};
        vecs[1] = '{hdr: 32'd4,           n: 4,       throttle: 1'b1, exp_err: 1'b0};
        vecs[2] = '{hdr: 32'd0,           n: 0,       throttle: 1'b0, exp_err: 1'b1};
        vecs[3] = '{hdr: 32'(H_DEPTH + 1), n: 0,      throttle: 1'b0, exp_err: 1'b1};
        vecs[4] = '{hdr: 32'd2,           n: 2,       throttle: 1'b0, exp_err: 1'b0};
        vecs[5] = '{hdr: 32'(H_DEPTH),    n: H_DEPTH, throttle: 1'b0, exp_err: 1'b0};
        vecs[6] = '{hdr: 32'd1,           n: 1,       throttle: 1'b1, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        h_rst = 1'b0;
        f_rst = 1'b0;
        chk("rst_cpu_rst", 32'(h_cpu_rst), 32'd1);
        chk("rst_we", 32'(h_we), 32'd0);
        chk("rst_addr", h_addr, 32'd0);
        chk("rst_data", h_imdata, 32'd0);
        chk("rst_ready", 32'(h_ready), 32'd0);
        chk("rst_flags", {29'd0, h_busy, h_done, h_err}, 32'd0);
        chk("rst_wl", 32'(h_wl), 32'd0);
        chk("f_rst_addr", f_addr, F_BASE);
        chk("f_rst_cpu_rst", 32'(f_cpu_rst), 32'd1);

        // Fixed-length image: first word is data even though it looks like a count.
        for (int unsigned i = 0; i < F_DEPTH; i++) begin
            fw[i] = (i == 0) ? 32'd3 : $urandom;
            f_q.push_back('{addr: F_BASE + 32'(i * 4), data: fw[i]});
        end
        @(negedge clk); f_start = 1'b1;
        @(negedge clk); f_start = 1'b0;
        chk("f_start_ready", 32'(f_ready), 32'd1);
        chk("f_start_busy", 32'(f_busy), 32'd1);
        for (int unsigned i = 0; i < F_DEPTH; i++) begin
            f_valid = 1'b1;
            f_data  = fw[i];
            @(negedge clk);
        end
        f_data = 32'hFFFF_FFFF;
        chk("f_ready_low", 32'(f_ready), 32'd0);
        chk("f_last_addr", f_addr, F_BASE + 32'h1C);
        chk("f_hold_cpu_rst", 32'(f_cpu_rst), 32'd1);
        @(negedge clk);
        f_valid = 1'b0;
        chk("f_run_cpu_rst", 32'(f_cpu_rst), 32'd0);
        f_start = 1'b1;
        @(negedge clk); f_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("f_run_forever", {30'd0, f_cpu_rst, f_done}, 32'd0);
        chk("f_busy_ignores_start", 32'(f_busy), 32'd1);
        chk("f_wl", 32'(f_wl), F_DEPTH);
        chk("f_write_count", f_wr, F_DEPTH);
        chk("f_sb_empty", f_q.size(), 32'd0);

        for (int unsigned vi = 0; vi < 7; vi++) h_load(vi);

        // Reset after 2 of 5 words: everything returns to reset values.
        wr0 = h_wr;
        for (int unsigned i = 0; i < 3; i++) mw[i] = $urandom;
        @(negedge clk); h_start = 1'b1;
        @(negedge clk); h_start = 1'b0;
        h_valid = 1'b1;
        h_data  = 32'd5;
        @(negedge clk);
        for (int unsigned i = 0; i < 2; i++) h_q.push_back('{addr: 32'(i * 4), data: mw[i]});
        h_data = mw[0];
        @(negedge clk);
        h_data = mw[1];
        @(negedge clk);
        h_data = mw[2];
        h_rst  = 1'b1;
        @(negedge clk);
        chk("mid_rst_cpu_rst", 32'(h_cpu_rst), 32'd1);
        chk("mid_rst_we", 32'(h_we), 32'd0);
        chk("mid_rst_addr", h_addr, 32'd0);
        chk("mid_rst_data", h_imdata, 32'd0);
        chk("mid_rst_ready", 32'(h_ready), 32'd0);
        chk("mid_rst_flags", {29'd0, h_busy, h_done, h_err}, 32'd0);
        chk("mid_rst_wl", 32'(h_wl), 32'd0);
        h_rst = 1'b0;
        repeat (4) @(negedge clk);
        h_valid = 1'b0;
        chk("mid_rst_write_count", h_wr - wr0, 32'd2);
        chk("mid_rst_sb_empty", h_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

endmodule
